// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
//   - op[5:4] mode encoding (basic / MUL / DIVU / REMU)
//   - op[3:0] basic-control encoding, unchanged from the single-cycle ALU
//   - controller state encoding
package alu_pkg;

  localparam logic [1:0] MODE_BASIC = 2'b00;
  localparam logic [1:0] MODE_MUL   = 2'b01;
  localparam logic [1:0] MODE_DIVU  = 2'b10;
  localparam logic [1:0] MODE_REMU  = 2'b11;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_basic_comb.sv
// Combinational W-bit basic ALU unit (logic and add-class ops).
// Ports:
//   ctl_i [3:0]  basic control: [3] invert A, [2] invert B and carry-in,
//                [1:0] select (00 AND, 01 OR, 10 SUM, 11 SLT)
//   a_i, b_i     operands
//   y_o          result
//   ovf_o        signed overflow, only for the SUM select
module alu_basic_comb #(
  parameter int W = 32
) (
  input  logic [3:0]   ctl_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         ovf_o
);

  logic [W-1:0] ai;
  logic [W-1:0] bi;
  logic [W-1:0] sum;

  always_comb begin
    ai  = ctl_i[3] ? ~a_i : a_i;
    bi  = ctl_i[2] ? ~b_i : b_i;
    // Carry-in equals the B-invert bit so that ~b + 1 forms -b for SUB/SLT.
    sum = ai + bi + {{(W-1){1'b0}}, ctl_i[2]};
    y_o = '0;
    unique case (ctl_i[1:0])
      2'b00: y_o = ai & bi;
      2'b01: y_o = ai | bi;
      2'b10: y_o = sum;
      2'b11: y_o = {{(W-1){1'b0}}, sum[W-1]};
      default: y_o = '0;
    endcase
    ovf_o = (ctl_i[1:0] == 2'b10) && (ai[W-1] == bi[W-1]) && (sum[W-1] != ai[W-1]);
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Basic ops complete in one cycle; unsigned MUL (shift-add), DIVU and REMU
// (restoring division) iterate one bit per cycle for W cycles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake; op, a, b latched on transfer
//   op [5:0]              [5:4] mode, [3:0] basic control
//   out_valid / out_ready result handshake; outputs held until consumed
//   result, zero, ovf, dbz registered result and flags
//
// state     | meaning
// ST_IDLE   | no operation, ready for a request
// ST_BUSY   | iterating MUL/DIVU/REMU, counter counts 0..W-1
// ST_DONE   | result held on the outputs until out_ready
module alu_mc
  import alu_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         ovf,
  output logic         dbz
);

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [1:0]    mode_q;
  // MUL: acc = partial product, shift = multiplier, mcand = multiplicand.
  // DIV: acc = partial remainder, shift = dividend/quotient, mcand = divisor.
  logic [W-1:0]  acc_q;
  logic [W-1:0]  shift_q;
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  result_q;
  logic          zero_q;
  logic          ovf_q;
  logic          dbz_q;

  logic          accept;
  logic          last_iter;
  logic          op_basic;
  logic [W-1:0]  basic_y;
  logic          basic_ovf;

  logic [W-1:0]  iter_acc;
  logic [W-1:0]  iter_shift;
  logic [W-1:0]  iter_mcand;
  logic [W-1:0]  iter_final;
  logic [W:0]    rem_sh;
  logic [W:0]    rem_diff;
  logic          rem_ge;

  alu_basic_comb #(.W(W)) u_basic (
    .ctl_i (op[3:0]),
    .a_i   (a),
    .b_i   (b),
    .y_o   (basic_y),
    .ovf_o (basic_ovf)
  );

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign op_basic  = (op[5:4] == MODE_BASIC);
  assign last_iter = (state_q == ST_BUSY) && (cnt_q == CW'(W - 1));

  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = op_basic ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (last_iter) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (accept) begin
          state_d = op_basic ? ST_DONE : ST_BUSY;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One iteration step for whichever multi-cycle op is in flight.
  always_comb begin
    rem_sh     = {acc_q, shift_q[W-1]};
    rem_diff   = rem_sh - {1'b0, mcand_q};
    rem_ge     = (rem_sh >= {1'b0, mcand_q});
    iter_acc   = acc_q;
    iter_shift = shift_q;
    iter_mcand = mcand_q;
    if (mode_q == MODE_MUL) begin
      iter_acc   = acc_q + (shift_q[0] ? mcand_q : '0);
      iter_shift = shift_q >> 1;
      iter_mcand = mcand_q << 1;
    end else begin
      // A zero divisor always compares "greater or equal", which naturally
      // yields an all-ones quotient and leaves the dividend as remainder.
      iter_acc   = rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0];
      iter_shift = {shift_q[W-2:0], rem_ge};
    end
    iter_final = (mode_q == MODE_DIVU) ? iter_shift : iter_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mode_q   <= MODE_BASIC;
      acc_q    <= '0;
      shift_q  <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (accept) begin
      mode_q <= op[5:4];
      if (op_basic) begin
        result_q <= basic_y;
        zero_q   <= (basic_y == '0);
        ovf_q    <= basic_ovf;
        dbz_q    <= 1'b0;
      end else begin
        cnt_q   <= '0;
        acc_q   <= '0;
        shift_q <= (op[5:4] == MODE_MUL) ? b : a;
        mcand_q <= (op[5:4] == MODE_MUL) ? a : b;
      end
    end else if (state_q == ST_BUSY) begin
      cnt_q   <= cnt_q + 1'b1;
      acc_q   <= iter_acc;
      shift_q <= iter_shift;
      mcand_q <= iter_mcand;
      if (last_iter) begin
        result_q <= iter_final;
        zero_q   <= (iter_final == '0);
        ovf_q    <= 1'b0;
        dbz_q    <= (mode_q != MODE_MUL) && (mcand_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam logic [5:0] OP_AND  = 6'b00_0000;
  localparam logic [5:0] OP_OR   = 6'b00_0001;
  localparam logic [5:0] OP_ADD  = 6'b00_0010;
  localparam logic [5:0] OP_SUB  = 6'b00_0110;
  localparam logic [5:0] OP_SLT  = 6'b00_0111;
  localparam logic [5:0] OP_NOR  = 6'b00_1100;
  localparam logic [5:0] OP_MUL  = 6'b01_0000;
  localparam logic [5:0] OP_DIVU = 6'b10_0000;
  localparam logic [5:0] OP_REMU = 6'b11_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  op;
  logic [31:0] a, b, result;
  logic        zero, ovf, dbz;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [5:0]  op8;
  logic [7:0]  a8, b8, result8;
  logic        zero8, ovf8, dbz8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .dbz(dbz)
  );

  alu_mc #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .zero(zero8), .ovf(ovf8), .dbz(dbz8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, wait for its result with out_ready high, check it.
  task automatic run_op(input string tag, input logic [5:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_ovf, input logic exp_dbz);
    int lat;
    logic rdy_busy;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = o; a = va; b = vb;
    tick();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0;
    lat = 1;
    rdy_busy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy = 1'b1;
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".res"}, 64'(result), 64'(exp_res));
    chk({tag, ".flags"}, {61'd0, zero, ovf, dbz}, {61'd0, exp_zero, exp_ovf, exp_dbz});
    if (exp_lat > 1) chk({tag, ".busy_rdy"}, 64'(rdy_busy), 64'd0);
  endtask

  initial begin
    logic        seen;
    logic [31:0] held_res;
    int          lat8;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = '0; a8 = '0; b8 = '0;
    tick(); tick();
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.res", 64'(result), 64'd0);
    chk("rst.flags", {61'd0, zero, ovf, dbz}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a MUL discards it.
    in_valid = 1'b1; op = OP_MUL; a = 32'd7; b = 32'd6;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst.valid", 64'(out_valid), 64'd0);
    chk("midrst.ready", 64'(in_ready), 64'd1);
    chk("midrst.res", 64'(result), 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst.stale", 64'(seen), 64'd0);

    run_op("sub_eq",  OP_SUB, 32'd5,         32'd5, 1, 32'h0,         1'b1, 1'b0, 1'b0);
    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("slt",     OP_SLT, 32'd3,         32'd9, 1, 32'h1,         1'b0, 1'b0, 1'b0);
    run_op("nor",     OP_NOR, 32'd0,         32'd0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("mul",     OP_MUL, 32'h0001_0003, 32'd5, 33, 32'h0005_000F, 1'b0, 1'b0, 1'b0);
    run_op("divu",    OP_DIVU, 32'd100,      32'd7, 33, 32'd14,       1'b0, 1'b0, 1'b0);
    run_op("remu",    OP_REMU, 32'd100,      32'd7, 33, 32'd2,        1'b0, 1'b0, 1'b0);
    run_op("divu0",   OP_DIVU, 32'd100,      32'd0, 33, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("remu0",   OP_REMU, 32'd100,      32'd0, 33, 32'd100,      1'b0, 1'b0, 1'b1);
    tick();

    // Back-to-back basic ops: one result per cycle.
    out_ready = 1'b1;
    in_valid = 1'b1; op = OP_AND; a = 32'h0000_F0F0; b = 32'h0000_FF00;
    tick();
    chk("b2b.and", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'h0000_F000});
    op = OP_OR;
    tick();
    chk("b2b.or", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'h0000_FFF0});
    op = OP_ADD; a = 32'd1; b = 32'd2;
    tick();
    chk("b2b.add", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd3});
    in_valid = 1'b0;
    tick();

    // Backpressure: result and flags hold while out_ready is low.
    out_ready = 1'b0;
    in_valid = 1'b1; op = OP_SUB; a = 32'h8000_0000; b = 32'd1;
    tick();
    in_valid = 1'b0;
    held_res = result;
    chk("bp.first", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'h7FFF_FFFF});
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (!out_valid || result !== 32'h7FFF_FFFF || !ovf || zero || dbz) seen = 1'b1;
    end
    chk("bp.stable", 64'(seen), 64'd0);
    chk("bp.held", 64'(held_res), 64'h7FFF_FFFF);
    out_ready = 1'b1;
    in_valid = 1'b1; op = OP_ADD; a = 32'd40; b = 32'd2;
    #1;
    chk("bp.ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.next", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd42});
    chk("bp.next_ovf", 64'(ovf), 64'd0);
    tick();

    // W=8 build: MUL 15*17 = 255.
    in_valid8 = 1'b1; op8 = OP_MUL; a8 = 8'd15; b8 = 8'd17;
    tick();
    in_valid8 = 1'b0;
    lat8 = 1;
    while (!out_valid8 && lat8 < 50) begin
      tick();
      lat8++;
    end
    chk("w8.lat", 64'(lat8), 64'd9);
    chk("w8.res", 64'(result8), 64'hFF);
    chk("w8.flags", {61'd0, zero8, ovf8, dbz8}, 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
